// File: rtl/pp3_run_detector.sv
// Serial run detector: z is high once w has been sampled 1 on RUN_LEN
// consecutive rising edges, and stays high until w=0 or Rst is sampled.
module pp3_run_detector #(
  parameter int RUN_LEN = 2
) (
  input  logic w,
  output logic z,
  input  logic Rst,
  input  logic Clk
);

  localparam int CNT_W = $clog2(RUN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_IDLE = '0;
  localparam logic [CNT_W-1:0] CNT_RUN  = CNT_W'(RUN_LEN);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             z_q, z_d;

  // Counter saturates at CNT_RUN so a long run never wraps back to idle.
  always_comb begin
    cnt_d = cnt_q;
    if (!w) begin
      cnt_d = CNT_IDLE;
    end else if (cnt_q != CNT_RUN) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // z is registered alongside the counter, so it never sees w combinationally.
  always_comb begin
    z_d = (cnt_d == CNT_RUN);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt_q <= CNT_IDLE;
      z_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      z_q   <= z_d;
    end
  end

  assign z = z_q;

endmodule

// File: tb/tb_pp3_run_detector.sv
// Bench for pp3_run_detector: directed sequence followed by random traffic,
// three instances (RUN_LEN 1, 2, 3) checked against a sample-history model.
`timescale 1ps/1ps
module tb_pp3_run_detector;

  logic clk_sys = 1'b0;
  logic rst     = 1'b1;
  logic w       = 1'b0;
  logic z1, z2, z3;

  int errors = 0;
  int checks = 0;

  // Samples of w taken since the last reset edge (most recent at the back).
  bit   hist[$];
  bit   reset_seen = 1'b0;

  always #100 clk_sys = ~clk_sys;

  pp3_run_detector #(.RUN_LEN(1)) u_dut1 (.w(w), .z(z1), .Rst(rst), .Clk(clk_sys));
  pp3_run_detector #(.RUN_LEN(2)) u_dut2 (.w(w), .z(z2), .Rst(rst), .Clk(clk_sys));
  pp3_run_detector #(.RUN_LEN(3)) u_dut3 (.w(w), .z(z3), .Rst(rst), .Clk(clk_sys));

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got z=%b expected z=%b", tag, $time, got, exp);
    end
  endtask

  // Detect when the last n samples since reset are all ones.
  function automatic bit model_z(input int n);
    if (hist.size() < n) return 1'b0;
    for (int k = 1; k <= n; k++)
      if (!hist[hist.size() - k]) return 1'b0;
    return 1'b1;
  endfunction

  // Drive inputs at edge+50, clock once, update model, compare at edge+25.
  task automatic step(input logic w_in, input logic rst_in, input string tag);
    w   = w_in;
    rst = rst_in;
    @(posedge clk_sys);
    if (rst_in) begin
      hist.delete();
      reset_seen = 1'b1;
    end else begin
      hist.push_back(w_in);
      if (hist.size() > 8) void'(hist.pop_front());
    end
    #25;
    if (reset_seen) begin
      chk({tag, "_L1"}, z1, model_z(1));
      chk({tag, "_L2"}, z2, model_z(2));
      chk({tag, "_L3"}, z3, model_z(3));
    end
    #25;
  endtask

  initial begin
    #50;
    // T1 reset through edge 100
    step(1'b0, 1'b1, "t1_reset");
    // T2 run of ones, saturation
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "t2_run");
    // T3 break
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, "t3_break");
    // T4 restart
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "t4_restart");
    // T5 reset mid-run with w held high, then fresh run
    step(1'b1, 1'b1, "t5_rst");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "t5_rerun");
    // T6 isolated pulses
    for (int i = 0; i < 10; i++) step(logic'(i % 2 == 0), 1'b0, "t6_pulse");
    // Random traffic biased toward ones, with occasional resets
    for (int i = 0; i < 400; i++) begin
      logic wr, rr;
      wr = ($urandom_range(99) < 70);
      rr = ($urandom_range(99) < 4);
      step(wr, rr, "rand");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
